// File: rtl/apb_slave_mem.sv
// APB completer: byte-strobed word register file, WAIT_CYCLES wait states.
// Ports: PCLK/PRESETn, APB requester inputs, PREADY/PRDATA/PSLVERR out.
// APB_SLV_PSLVERR_EN: when defined, out-of-range PADDR gives PSLVERR;
// otherwise addresses alias modulo DEPTH.
module apb_slave_mem #(
  parameter int ADDWIDTH    = 8,
  parameter int DATAWIDTH   = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [ADDWIDTH-1:0]    PADDR,
  input  logic [DATAWIDTH-1:0]   PWDATA,
  input  logic [DATAWIDTH/8-1:0] PSTRB,
  output logic                   PREADY,
  output logic [DATAWIDTH-1:0]   PRDATA,
  output logic                   PSLVERR
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB = DATAWIDTH / 8;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [DATAWIDTH-1:0] prdata_q;
  logic [IW-1:0] idx;
  logic addr_ok;
  logic setup;
  logic rd_load;
  logic wr_en;

  assign idx = PADDR[IW-1:0];

`ifdef APB_SLV_PSLVERR_EN
  // DEPTH is a power of two: in range iff no bits above idx
  assign addr_ok = ((PADDR >> IW) == '0);
`else
  logic unused_hi;
  assign unused_hi = ^(PADDR >> IW);
  assign addr_ok   = 1'b1;
`endif

  assign setup   = (state == S_IDLE) && PSEL && !PENABLE;
  assign PREADY  = (state == S_ACCESS) && PSEL && PENABLE
                   && (cnt == 8'd0);
  assign rd_load = setup && !PWRITE;
  assign wr_en   = PREADY && PWRITE && addr_ok;

`ifdef APB_SLV_PSLVERR_EN
  assign PSLVERR = PREADY && !addr_ok;
`else
  assign PSLVERR = 1'b0;
`endif

  assign PRDATA = prdata_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_nx = S_ACCESS;
          cnt_nx   = 8'(WAIT_CYCLES);
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          state_nx = S_IDLE;
          cnt_nx   = 8'd0;
        end else if (PENABLE) begin
          if (cnt == 8'd0) state_nx = S_IDLE;
          else             cnt_nx   = cnt - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      prdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (rd_load)
        prdata_q <= addr_ok ? mem[idx] : '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int w = 0; w < DEPTH; w++)
        mem[w] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (PSTRB[b])
          mem[idx][8*b +: 8] <= PWDATA[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem.
// Directed plan cases plus random APB traffic against a word-array model.
module tb_apb_slave_mem;

  localparam int WAITS = 2;
  localparam int DEP   = 64;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [DEP];

  apb_slave_mem #(
    .ADDWIDTH(8), .DATAWIDTH(32),
    .DEPTH(DEP), .WAIT_CYCLES(WAITS)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit a_valid(input int a);
`ifdef APB_SLV_PSLVERR_EN
    return a < DEP;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] m_read(input int a);
    return a_valid(a) ? mdl[a % DEP] : 32'h0;
  endfunction

  task automatic m_write(input int a, input logic [31:0] d,
                         input logic [3:0] s);
    if (a_valid(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[a % DEP][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic go_idle();
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    PENABLE = 1'b0;
  endtask

  // Full transfer; next call may follow immediately (no bubble).
  task automatic xfer(input bit wr, input int a,
                      input logic [31:0] d, input logic [3:0] s);
    int cyc;
    logic [31:0] exp_rd;
    exp_rd = m_read(a);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
    PADDR = 8'(a); PWDATA = d; PSTRB = s;
    @(negedge PCLK);
    check("setup_ready", {31'b0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cyc = 0;
    forever begin
      @(negedge PCLK);
      if (PREADY) break;
      check("no_err_wait", {31'b0, PSLVERR}, 32'd0);
      cyc++;
      if (cyc > 20) begin
        check("timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge PCLK); #1;
    end
    check("wait_states", cyc, WAITS);
    check("pslverr", {31'b0, PSLVERR},
          {31'b0, !a_valid(a)});
    if (!wr) check("rdata", PRDATA, exp_rd);
    if (wr) m_write(a, d, s);
  endtask

  initial begin
    int a;
    for (int i = 0; i < DEP; i++) mdl[i] = '0;

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_pready", {31'b0, PREADY}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    xfer(1'b0, 13, 32'h0, 4'h0);
    xfer(1'b1, 5, 32'hDEADBEEF, 4'hF);
    xfer(1'b0, 5, 32'h0, 4'h0);
    check("rd5_full", PRDATA, 32'hDEADBEEF);
    xfer(1'b1, 5, 32'h11223344, 4'h5);
    xfer(1'b0, 5, 32'h0, 4'h0);
    check("rd5_strb", PRDATA, 32'hDE22BE44);
    go_idle();

    // Abort: PSEL dropped in the first access cycle
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 8'd7; PWDATA = 32'hCAFEF00D; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b1;
    @(negedge PCLK);
    check("abort_ready", {31'b0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    PENABLE = 1'b0;
    xfer(1'b0, 7, 32'h0, 4'h0);
    check("rd7_abort", PRDATA, 32'h0);
    go_idle();

    // PENABLE without setup must not complete or write
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
    PADDR = 8'd9; PWDATA = 32'h12345678; PSTRB = 4'hF;
    repeat (4) begin
      @(negedge PCLK);
      check("viol_ready", {31'b0, PREADY}, 32'd0);
    end
    go_idle();
    xfer(1'b0, 9, 32'h0, 4'h0);

    // Out-of-range address 70
    xfer(1'b1, 70, 32'hA5A55A5A, 4'hF);
    xfer(1'b0, 70, 32'h0, 4'h0);
    xfer(1'b0, 6, 32'h0, 4'h0);
    go_idle();

    // Random traffic, with occasional gaps
    for (int n = 0; n < 150; n++) begin
      a = int'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) a = a % 8;
      xfer(1'($urandom_range(0, 1)), a, $urandom,
           4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) go_idle();
    end
    go_idle();

    // Reset during a write with cnt == 1
    xfer(1'b1, 11, 32'h55AA55AA, 4'hF);
    go_idle();
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 8'd12; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    #1;
    check("rst_mid_ready", {31'b0, PREADY}, 32'd0);
    check("rst_mid_prdata", PRDATA, 32'h0);
    for (int i = 0; i < DEP; i++) mdl[i] = '0;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("rst_hold_ready", {31'b0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    xfer(1'b0, 12, 32'h0, 4'h0);
    xfer(1'b0, 11, 32'h0, 4'h0);
    check("rd11_cleared", PRDATA, 32'h0);
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer that sits directly downstream of the APB requester: it consumes PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB and returns PREADY/PRDATA/PSLVERR. It is a byte-strobed word register file with a programmable number of wait states. One instance hangs off each requester select line.

## Interface
- ADDWIDTH, 8, width of PADDR; PADDR is a word index, not a byte address.
- DATAWIDTH, 32, data width; a multiple of 8.
- DEPTH, 64, number of words; a power of two, at most 2^ADDWIDTH.
- WAIT_CYCLES, 2, wait states inserted per access; range 0..255.
- PCLK  in  1  clock; all state changes on the rising edge.
- PRESETn  in  1  reset; asynchronous assert, active-low.
- PSEL  in  1  completer select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDWIDTH  word index.
- PWDATA  in  DATAWIDTH  write data.
- PSTRB  in  DATAWIDTH/8  byte-lane write strobes.
- PREADY  out  1  transfer completes this cycle.
- PRDATA  out  DATAWIDTH  read data.
- PSLVERR  out  1  error response; valid only while PREADY=1.

## Operation
- Two-state FSM with a wait counter `cnt` (8 bits).
  - **IDLE**
    - PSEL=1 and PENABLE=0 (setup phase): go to ACCESS and load `cnt` = WAIT_CYCLES.
    - Anything else: stay in IDLE. PENABLE=1 seen in IDLE is a protocol violation: PREADY stays 0 and there is no write.
  - **ACCESS**
    - PSEL=0 (abort): go to IDLE. No write, no error, `cnt` is discarded.
    - PSEL=1, PENABLE=1, `cnt`≠0: decrement `cnt` and stay in ACCESS.
    - PSEL=1, PENABLE=1, `cnt`=0: transfer completes and the FSM goes to IDLE.
- PREADY is combinational: (state=ACCESS) & PSEL & PENABLE & (`cnt`=0).
- Write: commits on the rising edge of the completing cycle, for a valid address only. Byte lane i of mem[idx] is updated iff PSTRB[i]=1. PSTRB=0 is a legal no-op write.
- Read: PRDATA is a register loaded at the end of the setup cycle (IDLE, PSEL=1, PENABLE=0, PWRITE=0).
  - Load value: mem[idx], or 0 if the address is invalid.
  - PRDATA holds its value until the next read setup. Writes never change PRDATA.
- idx = PADDR[log2(DEPTH)-1:0].
- Write in cycle N followed by a read setup in cycle N+1 returns the new data.
- PSLVERR behaviour depends on configuration; it is 0 whenever PREADY=0.

## Timing
- Reset values (asynchronous): state = IDLE, `cnt` = 0, PRDATA = 0, all mem words = 0. Therefore PREADY = 0 and PSLVERR = 0.
- Setup cycle at T0; access cycles T1..T1+W, where W = WAIT_CYCLES. PREADY is high exactly at T1+W.
  - WAIT_CYCLES=0 gives a zero-wait transfer.
- Back-to-back: a new setup in the cycle right after completion is accepted with no bubble.
- PADDR/PWRITE/PWDATA/PSTRB are sampled at completion (writes) or at setup (reads). They are required to be stable over the whole transfer.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately, PREADY drops to 0, the pending write is lost and mem is cleared.

## Configuration
- APB_SLV_PSLVERR_EN defined:
  - PADDR ≥ DEPTH is invalid.
  - Completion of an invalid access asserts PSLVERR=1 together with PREADY.
  - Invalid writes are dropped; invalid reads load PRDATA = 0.
- Undefined:
  - PSLVERR is tied to 0.
  - Every address is valid and aliases modulo DEPTH through idx.

## Test plan
- Reset, then release, with WAIT_CYCLES=2 -> PREADY=0, PRDATA=0, PSLVERR=0; read of any address returns 0.
- Write 0xDEADBEEF to addr 5 with PSTRB=0xF -> PREADY high exactly 2 cycles after PENABLE rises; a subsequent read of addr 5 returns 0xDEADBEEF.
- Write 0x11223344 to addr 5 with PSTRB=0x5 -> read of addr 5 returns 0xDE22BE44.
- PSEL dropped at T1 during a write to addr 7 -> no PREADY; a subsequent read of addr 7 returns 0.
- Write then read addr 70 (DEPTH=64):
  - With APB_SLV_PSLVERR_EN: PSLVERR=1 with PREADY, and the read returns 0.
  - Without it: the read of addr 6 returns the data written to addr 70, and PSLVERR stays 0.
- Reset asserted while `cnt`=1 mid-write -> PREADY=0 immediately; after release, a read of the target address returns 0.
